pcie_to_pc_fifo: RTL and testbench
==================================

# pcie_to_pc_fifo

Streams 64-bit words from FPGA logic to host memory over PCI Express: it buffers words into 512-byte blocks in an 8-block reorder/staging RAM and issues one posted memory-write request per full block to the TLP transmit arbiter. It is the FPGA-to-PC counterpart of the from-PC read-request FIFO. It sits between the user FIFO port and the PCIe write-request path, and is controlled through the same PIO register scheme: a stop pointer and an interrupt pointer.

## Interface
Parameters:
- none; buffer is fixed at 8 blocks × 64 words (512 × 64-bit RAM).

Ports:
- clock  in  1  single clock for all logic, including the FIFO port
- reset  in  1  synchronous, active-high
- interrupt  out  1  one-cycle pulse when the sent-block count reaches the interrupt pointer
- status  out  32  {6'd0, p_sent[16:0], 9'd0}: bytes sent
- pio_wvalid  in  1  PIO register write strobe
- pio_wdata  in  64  PIO write data
- pio_addr  in  4  register select: 6 = stop pointer, 7 = interrupt pointer
- wr_valid  out  1  write request pending
- wr_addr  out  64  byte offset of the block, zero-extended {p_sent[16:0], 9'd0}
- wr_ready  in  1  transmitter accepts the request (sampled only while wr_valid)
- wr_data_read  in  1  transmitter pulls the next payload word
- wr_data  out  64  payload word
- wr_data_valid  out  1  wr_data is valid
- fifo_write  in  1  user word write
- fifo_write_data  in  64  user word
- fifo_ready  out  1  space is available; writes while low are dropped

## Operation
- Registers:
  - p_in[22:0]: word write pointer; [8:0] is the RAM address and [22:6] is the count of filled blocks.
  - p_sent[16:0]: blocks sent.
  - p_stop[16:0]: stop pointer.
  - p_int[16:0]: interrupt pointer.
  - rd_idx[5:0]: payload word index.
- PIO:
  - A write with pio_addr == 6 loads p_stop <= pio_wdata[25:9].
  - A write with pio_addr == 7 loads p_int <= pio_wdata[25:9].
  - Both writes take effect on the next cycle.
- fifo_ready = ((p_in[22:6] - p_sent) mod 2^17) < 8.
  - When fifo_write && fifo_ready: RAM[p_in[8:0]] <= data and p_in increments.
- FSM:
  - IDLE -> REQ when p_in[22:6] != p_sent and p_sent != p_stop.
  - REQ: wr_valid = 1. On wr_valid && wr_ready, go to DATA and clear rd_idx.
  - DATA: each wr_data_read reads RAM[{p_sent[2:0], rd_idx}] and increments rd_idx.
  - On the read with rd_idx == 63, go to IDLE and increment p_sent on the same edge.
  - wr_data_read outside DATA is ignored.
- Block slot p_sent[2:0] is freed when p_sent increments. A concurrent fifo_write into word 0 of that slot cannot collide with the final read of word 63.
- Interrupt fires when p_sent increments to a value equal to p_int. It does not fire for a static match, such as after reset with p_int == 0.
- Changing p_stop during REQ or DATA does not abort the current block. It is evaluated at the next IDLE check.
- All 17-bit pointer arithmetic is modulo 2^17; wrap is seamless.

## Timing
- Reset values:
  - p_in, p_sent, p_stop, p_int, rd_idx = 0; FSM = IDLE.
  - interrupt = 0, wr_valid = 0, wr_data_valid = 0, wr_data = 0.
  - fifo_ready = 1 in the first cycle after reset.
- Reset during DATA abandons the block: no further wr_data_valid pulses.
- fifo_ready is combinational from registers. A write accepted at edge N is counted in fifo_ready from cycle N+1.
- Request latency:
  - The 64th word is written at edge N.
  - The FSM enters REQ at edge N+1, so wr_valid is high from cycle N+1.
  - wr_valid is low on the cycle after acceptance.
- Payload: wr_data / wr_data_valid is a registered RAM read plus an output register.
  - wr_data_read at edge N gives wr_data_valid high during cycle N+2.
  - Exactly 64 wr_data_valid pulses per block, in address order.
  - Read strobes need not be contiguous.
- interrupt is high in the cycle after the p_sent increment.
- status follows p_sent with no extra delay.

## Test plan
- Reset, then write 64 words 0..63 with p_stop = 1 -> one wr_valid with wr_addr = 0. Holding wr_data_read high for 64 cycles gives data 0..63, with each word 2 cycles after its strobe. Afterwards status = 0x200 and wr_valid stays low.
- p_stop = 0, write 512 words -> fifo_ready is low after the 512th; a 513th write is dropped and there is no wr_valid. Set p_stop = 8 -> 8 requests with wr_addr 0x000..0xE00. fifo_ready rises after the first block completes.
- p_stop = 20, stream 1280 incrementing words under random wr_ready / wr_data_read stalls -> 20 blocks with contiguous data across the RAM wrap; final status = 0x2800.
- p_int = 3 (pio_wdata = 0x600), send 4 blocks -> exactly one interrupt pulse, the cycle after p_sent goes 2 -> 3.
- Assert reset mid-DATA after 10 reads -> no further wr_data_valid; status = 0, fifo_ready = 1, wr_valid = 0. New blocks then restart at wr_addr = 0.
- Drive wr_data_read in IDLE and REQ, and fifo_write while fifo_ready is low -> no pointer changes and no wr_data_valid pulses.

Source files
------------

// File: rtl/pcie_to_pc_fifo.sv
// pcie_to_pc_fifo: stages user words into 8 x 512-byte blocks and issues
// one posted write request per full block toward the PCIe TLP transmitter.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   interrupt           one-cycle pulse when p_sent steps onto p_int
//   status              {6'd0, p_sent, 9'd0}: bytes sent
//   pio_wvalid/wdata/addr  register writes (6 = stop ptr, 7 = interrupt ptr)
//   wr_valid/wr_addr/wr_ready  write request handshake, byte offset of block
//   wr_data_read        transmitter pulls the next payload word
//   wr_data/wr_data_valid  payload, two cycles after each pull
//   fifo_write/fifo_write_data/fifo_ready  user word port
module pcie_to_pc_fifo (
    input  logic        clock,
    input  logic        reset,
    output logic        interrupt,
    output logic [31:0] status,
    input  logic        pio_wvalid,
    input  logic [63:0] pio_wdata,
    input  logic [3:0]  pio_addr,
    output logic        wr_valid,
    output logic [63:0] wr_addr,
    input  logic        wr_ready,
    input  logic        wr_data_read,
    output logic [63:0] wr_data,
    output logic        wr_data_valid,
    input  logic        fifo_write,
    input  logic [63:0] fifo_write_data,
    output logic        fifo_ready
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [22:0] p_in;
    logic [16:0] p_sent;
    logic [16:0] p_stop;
    logic [16:0] p_int;
    logic [16:0] blk_used;
    logic [5:0]  rd_idx;
    logic [63:0] ram [0:511];
    logic [63:0] rd_q;
    logic        rd_q_valid;
    logic        wr_en;
    logic        rd_en;
    logic        last_rd;
    logic        unused_pio;

    // Only bits [25:9] of a PIO write carry a block pointer.
    assign unused_pio = ^{pio_wdata[63:26], pio_wdata[8:0]};

    // Filled-but-unsent blocks; modulo arithmetic keeps wrap seamless.
    assign blk_used   = p_in[22:6] - p_sent;
    assign fifo_ready = blk_used < 17'd8;
    assign wr_en      = fifo_write && fifo_ready;
    assign rd_en      = (state == DATA) && wr_data_read;
    assign last_rd    = rd_en && (rd_idx == 6'd63);

    assign status  = {6'd0, p_sent, 9'd0};
    assign wr_addr = {38'd0, p_sent, 9'd0};

    always_comb begin
        state_nx = state;
        wr_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if ((p_in[22:6] != p_sent) && (p_sent != p_stop)) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                wr_valid = 1'b1;
                if (wr_ready) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (last_rd) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            p_in          <= '0;
            p_sent        <= '0;
            p_stop        <= '0;
            p_int         <= '0;
            rd_idx        <= '0;
            interrupt     <= 1'b0;
            rd_q_valid    <= 1'b0;
            wr_data_valid <= 1'b0;
            wr_data       <= '0;
        end else begin
            state <= state_nx;
            if (pio_wvalid && (pio_addr == 4'd6)) begin
                p_stop <= pio_wdata[25:9];
            end
            if (pio_wvalid && (pio_addr == 4'd7)) begin
                p_int <= pio_wdata[25:9];
            end
            if (wr_en) begin
                p_in <= p_in + 23'd1;
            end
            if (state == REQ && wr_ready) begin
                rd_idx <= '0;
            end else if (rd_en) begin
                rd_idx <= rd_idx + 6'd1;
            end
            if (last_rd) begin
                p_sent <= p_sent + 17'd1;
            end
            // Fires only on the step onto p_int, never on a static match.
            interrupt     <= last_rd && ((p_sent + 17'd1) == p_int);
            rd_q_valid    <= rd_en;
            wr_data_valid <= rd_q_valid;
            if (rd_q_valid) begin
                wr_data <= rd_q;
            end
        end
    end

    // Staging RAM: the slot being drained is never the one being filled
    // at the same address, so no bypass is needed.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            ram[p_in[8:0]] <= fifo_write_data;
        end
        if (rd_en) begin
            rd_q <= ram[{p_sent[2:0], rd_idx}];
        end
    end

endmodule

// File: tb/tb_pcie_to_pc_fifo.sv
// tb_pcie_to_pc_fifo: scoreboard bench for pcie_to_pc_fifo.
// Payload words are queued when written and popped as they come out.
module tb_pcie_to_pc_fifo;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        interrupt;
    logic [31:0] status;
    logic        pio_wvalid = 1'b0;
    logic [63:0] pio_wdata = '0;
    logic [3:0]  pio_addr = '0;
    logic        wr_valid;
    logic [63:0] wr_addr;
    logic        wr_ready;
    logic        wr_data_read;
    logic [63:0] wr_data;
    logic        wr_data_valid;
    logic        fifo_write = 1'b0;
    logic [63:0] fifo_write_data = '0;
    logic        fifo_ready;

    int          n_chk = 0;
    int          n_pass = 0;
    longint      cyc = 0;
    logic [63:0] sb[$];
    int          n_dv = 0;
    int          irq_cnt = 0;
    logic [31:0] irq_stat = '0;
    int          exp_blk = 0;
    longint      first_dv_cyc = -1;
    longint      strobe_cyc = 0;
    int          resp_mode = 0;
    logic        man_ready = 1'b0;
    logic        man_read = 1'b0;
    logic        rnd_ready = 1'b1;
    logic        rnd_read = 1'b1;
    int          dv0;

    assign wr_ready     = (resp_mode == 0) ? man_ready : rnd_ready;
    assign wr_data_read = (resp_mode == 0) ? man_read : rnd_read;

    pcie_to_pc_fifo dut (
        .clock          (clock),
        .reset          (reset),
        .interrupt      (interrupt),
        .status         (status),
        .pio_wvalid     (pio_wvalid),
        .pio_wdata      (pio_wdata),
        .pio_addr       (pio_addr),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_ready       (wr_ready),
        .wr_data_read   (wr_data_read),
        .wr_data        (wr_data),
        .wr_data_valid  (wr_data_valid),
        .fifo_write     (fifo_write),
        .fifo_write_data(fifo_write_data),
        .fifo_ready     (fifo_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (resp_mode == 2) begin
                rnd_ready = ($urandom_range(0, 1) == 1);
                rnd_read  = ($urandom_range(0, 3) != 0);
            end else begin
                rnd_ready = 1'b1;
                rnd_read  = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_blk      = 0;
                irq_cnt      = 0;
                first_dv_cyc = -1;
            end else begin
                if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
                    check("wr_addr", wr_addr, 64'(exp_blk) << 9);
                    exp_blk++;
                end
                if (wr_data_valid === 1'b1) begin
                    n_dv++;
                    if (first_dv_cyc < 0) first_dv_cyc = cyc;
                    if (sb.size() == 0) begin
                        check("extra_dv", 64'(wr_data_valid), 64'd0);
                    end else begin
                        check("wr_data", wr_data, sb.pop_front());
                    end
                end
                if (interrupt === 1'b1) begin
                    irq_cnt++;
                    irq_stat = status;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset      = 1'b1;
        fifo_write = 1'b0;
        pio_wvalid = 1'b0;
        man_ready  = 1'b0;
        man_read   = 1'b0;
        resp_mode  = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clock);
        check("rst_status", 64'(status), 64'd0);
        check("rst_ready", 64'(fifo_ready), 64'd1);
        check("rst_wv", 64'(wr_valid), 64'd0);
        check("rst_dv", 64'(wr_data_valid), 64'd0);
        check("rst_data", wr_data, 64'd0);
        check("rst_irq", 64'(interrupt), 64'd0);
    endtask

    task automatic pio(input logic [3:0] a, input logic [63:0] d);
        @(posedge clock);
        #1;
        pio_wvalid = 1'b1;
        pio_addr   = a;
        pio_wdata  = d;
        @(posedge clock);
        #1;
        pio_wvalid = 1'b0;
    endtask

    task automatic write_words(input logic [63:0] base, input int n,
                               input bit gaps);
        int i = 0;
        int budget = 0;
        while (i < n && budget < 20000) begin
            @(posedge clock);
            #1;
            budget++;
            if (gaps && $urandom_range(0, 3) == 0) begin
                fifo_write = 1'b0;
            end else if (fifo_ready) begin
                fifo_write      = 1'b1;
                fifo_write_data = base + 64'(i);
                sb.push_back(base + 64'(i));
                i++;
            end else begin
                fifo_write = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        fifo_write = 1'b0;
        check("wr_count", 64'(i), 64'(n));
    endtask

    task automatic wait_done(input string tag, input logic [31:0] st,
                             input int budget);
        int k = 0;
        while (k < budget && !(status == st && sb.size() == 0)) begin
            @(negedge clock);
            k++;
        end
        check(tag, 64'(status), 64'(st));
        check({tag, "_drain"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_wv(input string tag);
        int k = 0;
        while (k < 50 && wr_valid !== 1'b1) begin
            @(negedge clock);
            k++;
        end
        check(tag, 64'(wr_valid), 64'd1);
    endtask

    initial begin
        // single block, exact latencies
        do_reset();
        pio(4'd6, 64'h200);
        write_words(64'd0, 64, 1'b0);
        @(negedge clock);
        check("t1_req_lat0", 64'(wr_valid), 64'd0);
        @(negedge clock);
        check("t1_req_lat1", 64'(wr_valid), 64'd1);
        dv0 = n_dv;
        @(posedge clock);
        #1;
        man_ready = 1'b1;
        @(posedge clock);
        #1;
        man_ready  = 1'b0;
        man_read   = 1'b1;
        strobe_cyc = cyc;
        @(negedge clock);
        check("t1_wv_drop", 64'(wr_valid), 64'd0);
        repeat (64) @(posedge clock);
        #1;
        man_read = 1'b0;
        wait_done("t1_status", 32'h200, 50);
        check("t1_lat", 64'(first_dv_cyc - strobe_cyc), 64'd2);
        check("t1_cnt", 64'(n_dv - dv0), 64'd64);
        repeat (5) @(negedge clock);
        check("t1_idle", 64'(wr_valid), 64'd0);

        // fill all 8 slots, drop a 9th-block write, then drain
        do_reset();
        write_words(64'h1000, 512, 1'b0);
        check("t2_full", 64'(fifo_ready), 64'd0);
        fifo_write      = 1'b1;
        fifo_write_data = 64'hDEAD;
        @(posedge clock);
        #1;
        fifo_write = 1'b0;
        repeat (5) @(negedge clock);
        check("t2_noreq", 64'(wr_valid), 64'd0);
        check("t2_still_full", 64'(fifo_ready), 64'd0);
        dv0 = n_dv;
        pio(4'd6, 64'h1000);
        resp_mode = 1;
        begin
            int k = 0;
            while (k < 300 && status != 32'h200) begin
                @(negedge clock);
                k++;
            end
        end
        check("t2_first", 64'(status), 64'h200);
        check("t2_ready", 64'(fifo_ready), 64'd1);
        wait_done("t2_status", 32'h1000, 1000);
        check("t2_cnt", 64'(n_dv - dv0), 64'd512);
        check("t2_blk", 64'(exp_blk), 64'd8);

        // 20 blocks with random stalls across the RAM wrap
        do_reset();
        pio(4'd6, 64'h2800);
        resp_mode = 2;
        write_words(64'h5000_0000, 1280, 1'b1);
        wait_done("t3_status", 32'h2800, 20000);
        check("t3_blk", 64'(exp_blk), 64'd20);

        // interrupt on p_sent 2 -> 3
        do_reset();
        pio(4'd7, 64'h600);
        pio(4'd6, 64'h800);
        resp_mode = 1;
        write_words(64'h7700, 256, 1'b0);
        wait_done("t4_status", 32'h800, 2000);
        check("t4_irq_cnt", 64'(irq_cnt), 64'd1);
        check("t4_irq_at", 64'(irq_stat), 64'h600);

        // reset in the middle of a block
        do_reset();
        pio(4'd6, 64'h200);
        write_words(64'h9000, 64, 1'b0);
        wait_wv("t5_req");
        dv0 = n_dv;
        @(posedge clock);
        #1;
        man_ready = 1'b1;
        @(posedge clock);
        #1;
        man_ready = 1'b0;
        man_read  = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        man_read = 1'b0;
        repeat (3) @(negedge clock);
        check("t5_partial", 64'(n_dv - dv0), 64'd10);
        do_reset();
        dv0 = n_dv;
        @(posedge clock);
        #1;
        man_read = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        man_read = 1'b0;
        repeat (3) @(negedge clock);
        check("t5_no_dv", 64'(n_dv - dv0), 64'd0);
        pio(4'd6, 64'h200);
        resp_mode = 1;
        write_words(64'hA000, 64, 1'b0);
        wait_done("t5_restart", 32'h200, 300);
        check("t5_blk", 64'(exp_blk), 64'd1);

        // stray reads in IDLE and REQ
        do_reset();
        dv0 = n_dv;
        @(posedge clock);
        #1;
        man_read = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        man_read = 1'b0;
        write_words(64'hB000, 64, 1'b0);
        repeat (3) @(negedge clock);
        check("t6_idle_req", 64'(wr_valid), 64'd0);
        pio(4'd6, 64'h200);
        wait_wv("t6_req");
        @(posedge clock);
        #1;
        man_read = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        man_read = 1'b0;
        repeat (3) @(negedge clock);
        check("t6_no_dv", 64'(n_dv - dv0), 64'd0);
        check("t6_status", 64'(status), 64'd0);
        resp_mode = 1;
        wait_done("t6_done", 32'h200, 300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
